// File: rtl/pipeline_run_controller_pkg.sv
// rtl/pipeline_run_controller_pkg.sv - shared run-controller state codes and stall helpers
package pipeline_run_controller_pkg;

  // UART-visible state codes; the UART and ID decoders depend on these values
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_STEP  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  localparam logic [5:0] HALT_OPCODE = 6'h3F;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic id_ex_bubble;
  } stall_ctrl_t;

  function automatic stall_ctrl_t stall_ctrl(input logic hold);
    stall_ctrl_t s;
    s.pc_write     = ~hold;
    s.if_id_write  = ~hold;
    s.id_ex_bubble = hold;
    return s;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational load-use hazard compare
module hazard_detect (
  input  logic       EX_mem_read,
  input  logic [4:0] EX_rt,
  input  logic [4:0] ID_rs,
  input  logic [4:0] ID_rt,
  output logic       hz
);

  // $zero is never a real dependency, so a load into r0 cannot stall
  assign hz = EX_mem_read && (EX_rt != 5'd0) && ((EX_rt == ID_rs) || (EX_rt == ID_rt));

endmodule

// File: rtl/pipeline_run_controller.sv
// rtl/pipeline_run_controller.sv - run/step/halt/drain sequencer and load-use stall control
module pipeline_run_controller
  import pipeline_run_controller_pkg::*;
#(
  parameter int CNT_W        = 32,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             run_cmd,
  input  logic             step_cmd,
  input  logic             halt_cmd,
  input  logic             clr_cnt,
  input  logic             halt_instr,
  input  logic [4:0]       ID_rs,
  input  logic [4:0]       ID_rt,
  input  logic [4:0]       EX_rt,
  input  logic             EX_mem_read,
  input  logic             branch_taken,
  input  logic             jump_sel,
  output logic             enable,
  output logic             PC_write,
  output logic             IF_ID_write,
  output logic             ID_EX_bubble,
  output logic [1:0]       state,
  output logic             done,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int              DW         = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0]   DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

  logic [1:0]    next_state;
  logic [DW-1:0] drain_cnt;
  logic [DW-1:0] drain_next;
  logic          done_next;
  logic          hz;
  stall_ctrl_t   ctrl;

  hazard_detect u_hazard_detect (
    .EX_mem_read (EX_mem_read),
    .EX_rt       (EX_rt),
    .ID_rs       (ID_rs),
    .ID_rt       (ID_rt),
    .hz          (hz)
  );

  always_comb begin
    next_state = state;
    drain_next = drain_cnt;
    done_next  = 1'b0;
    case (state)
      S_IDLE: begin
        if (run_cmd)       next_state = S_RUN;
        else if (step_cmd) next_state = S_STEP;
      end
      S_RUN: begin
        if (halt_cmd) begin
          next_state = S_IDLE;
        end else if (halt_instr) begin
          next_state = S_DRAIN;
          drain_next = DRAIN_LOAD;
        end
      end
      S_STEP: begin
        if (halt_cmd) begin
          next_state = S_IDLE;
        end else if (halt_instr) begin
          next_state = S_DRAIN;
          drain_next = DRAIN_LOAD;
        end else begin
          next_state = S_IDLE;
        end
      end
      S_DRAIN: begin
        // An operator halt aborts the drain silently; only a natural finish reports done
        if (halt_cmd) begin
          next_state = S_IDLE;
        end else if (drain_cnt == '0) begin
          next_state = S_IDLE;
          done_next  = 1'b1;
        end else begin
          drain_next = drain_cnt - 1'b1;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      drain_cnt <= '0;
      done      <= 1'b0;
    end else begin
      state     <= next_state;
      drain_cnt <= drain_next;
      done      <= done_next;
    end
  end

  assign enable = (state != S_IDLE);

  // Taken branch/jump flushes IF_ID itself, so the stall would only lose a cycle
  always_comb begin
    if (state == S_DRAIN) ctrl = stall_ctrl(1'b1);
    else                  ctrl = stall_ctrl(enable && hz && !(branch_taken || jump_sel));
  end

  assign PC_write     = ctrl.pc_write;
  assign IF_ID_write  = ctrl.if_id_write;
  assign ID_EX_bubble = ctrl.id_ex_bubble;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cycle_count <= '0;
    end else if (clr_cnt) begin
      cycle_count <= '0;
    end else if (enable && (cycle_count != {CNT_W{1'b1}})) begin
      cycle_count <= cycle_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_run_controller.sv
// tb/tb_pipeline_run_controller.sv - randomized and directed bench with behavioural model
module tb_pipeline_run_controller;

  localparam int DRAIN = 4;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic run_cmd = 0, step_cmd = 0, halt_cmd = 0, clr_cnt = 0, halt_instr = 0;
  logic [4:0] ID_rs = 0, ID_rt = 0, EX_rt = 0;
  logic EX_mem_read = 0, branch_taken = 0, jump_sel = 0;

  logic        enable, PC_write, IF_ID_write, ID_EX_bubble, done;
  logic [1:0]  state;
  logic [31:0] cycle_count;
  logic        enable4, PC_write4, IF_ID_write4, ID_EX_bubble4, done4;
  logic [1:0]  state4;
  logic [3:0]  cycle_count4;

  int n_checks = 0;
  int n_errors = 0;

  int      m_state = 0;
  int      m_left  = 0;
  bit      m_done  = 0;
  longint  m_cnt   = 0;
  longint  m_cnt4  = 0;

  always #5 clock = ~clock;

  pipeline_run_controller #(.CNT_W(32), .DRAIN_CYCLES(DRAIN)) dut (
    .clock(clock), .reset_n(reset_n), .run_cmd(run_cmd), .step_cmd(step_cmd),
    .halt_cmd(halt_cmd), .clr_cnt(clr_cnt), .halt_instr(halt_instr),
    .ID_rs(ID_rs), .ID_rt(ID_rt), .EX_rt(EX_rt), .EX_mem_read(EX_mem_read),
    .branch_taken(branch_taken), .jump_sel(jump_sel), .enable(enable),
    .PC_write(PC_write), .IF_ID_write(IF_ID_write), .ID_EX_bubble(ID_EX_bubble),
    .state(state), .done(done), .cycle_count(cycle_count)
  );

  pipeline_run_controller #(.CNT_W(4), .DRAIN_CYCLES(DRAIN)) dut4 (
    .clock(clock), .reset_n(reset_n), .run_cmd(run_cmd), .step_cmd(step_cmd),
    .halt_cmd(halt_cmd), .clr_cnt(clr_cnt), .halt_instr(halt_instr),
    .ID_rs(ID_rs), .ID_rt(ID_rt), .EX_rt(EX_rt), .EX_mem_read(EX_mem_read),
    .branch_taken(branch_taken), .jump_sel(jump_sel), .enable(enable4),
    .PC_write(PC_write4), .IF_ID_write(IF_ID_write4), .ID_EX_bubble(ID_EX_bubble4),
    .state(state4), .done(done4), .cycle_count(cycle_count4)
  );

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mode plus number of drain cycles still to spend
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_state = 0; m_left = 0; m_done = 0; m_cnt = 0; m_cnt4 = 0;
    end else begin
      if (clr_cnt) begin
        m_cnt = 0; m_cnt4 = 0;
      end else if (m_state != 0) begin
        if (m_cnt  < 64'hFFFF_FFFF) m_cnt++;
        if (m_cnt4 < 15)            m_cnt4++;
      end
      m_done = 0;
      case (m_state)
        0: if (run_cmd) m_state = 1; else if (step_cmd) m_state = 2;
        1: if (halt_cmd) m_state = 0;
           else if (halt_instr) begin m_state = 3; m_left = DRAIN; end
        2: if (halt_cmd) m_state = 0;
           else if (halt_instr) begin m_state = 3; m_left = DRAIN; end
           else m_state = 0;
        default: if (halt_cmd) m_state = 0;
                 else begin
                   m_left--;
                   if (m_left == 0) begin m_state = 0; m_done = 1; end
                 end
      endcase
    end
  end

  always @(negedge clock) begin
    bit e_en, e_hz, e_hold;
    e_en   = (m_state != 0);
    e_hz   = EX_mem_read && EX_rt != 0 && (EX_rt == ID_rs || EX_rt == ID_rt);
    e_hold = (m_state == 3) || (e_en && e_hz && !(branch_taken || jump_sel));
    check("state",        state,        m_state);
    check("enable",       enable,       e_en);
    check("PC_write",     PC_write,     !e_hold);
    check("IF_ID_write",  IF_ID_write,  !e_hold);
    check("ID_EX_bubble", ID_EX_bubble, e_hold);
    check("done",         done,         m_done);
    check("cycle_count",  cycle_count,  m_cnt);
    check("state4",       state4,       m_state);
    check("cycle_count4", cycle_count4, m_cnt4);
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs;
    run_cmd = 0; step_cmd = 0; halt_cmd = 0; clr_cnt = 0; halt_instr = 0;
    ID_rs = 0; ID_rt = 0; EX_rt = 0; EX_mem_read = 0; branch_taken = 0; jump_sel = 0;
  endtask

  initial begin
    int en_hi, d_cnt, done_seen, pc_bad;
    #12 reset_n = 1'b1;
    #1;
    check("reset_state",   state, 0);
    check("reset_enable",  enable, 0);
    check("reset_PC_write", PC_write, 1);
    check("reset_count",   cycle_count, 0);
    check("reset_done",    done, 0);

    // Single step x3
    tick;
    en_hi = 0;
    for (int s = 0; s < 3; s++) begin
      step_cmd = 1;
      tick;
      step_cmd = 0;
      en_hi += int'(enable);
      for (int g = 0; g < 5; g++) begin
        tick;
        en_hi += int'(enable);
      end
    end
    check("step_enable_clocks", en_hi, 3);
    check("step_count", cycle_count, 3);
    check("step_state", state, 0);

    // Load-use in RUN
    run_cmd = 1; tick; run_cmd = 0;
    EX_mem_read = 1; EX_rt = 5; ID_rs = 5; #1;
    check("lu_PC_write", PC_write, 0);
    check("lu_IF_ID_write", IF_ID_write, 0);
    check("lu_bubble", ID_EX_bubble, 1);
    EX_rt = 0; ID_rs = 0; #1;
    check("lu_r0_PC_write", PC_write, 1);
    EX_rt = 5; ID_rs = 5; branch_taken = 1; #1;
    check("lu_branch_PC_write", PC_write, 1);
    check("lu_branch_bubble", ID_EX_bubble, 0);
    clear_inputs;

    // Halt drain
    halt_instr = 1; tick; halt_instr = 0;
    d_cnt = 0; done_seen = 0; pc_bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (state == 2'd3) begin
        d_cnt++;
        if (PC_write !== 1'b0) pc_bad++;
      end
      if (done) done_seen++;
      tick;
    end
    check("drain_clocks", d_cnt, 4);
    check("drain_pc_held", pc_bad, 0);
    check("drain_done_pulses", done_seen, 1);
    check("drain_end_state", state, 0);
    check("drain_end_enable", enable, 0);

    // Priority
    run_cmd = 1; step_cmd = 1; tick; clear_inputs;
    check("prio_run_over_step", state, 1);
    halt_cmd = 1; halt_instr = 1; tick; clear_inputs;
    check("prio_halt_cmd", state, 0);
    done_seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (done) done_seen++;
      tick;
    end
    check("prio_no_done", done_seen, 0);

    // Counter saturation on the 4-bit instance
    clr_cnt = 1; tick; clr_cnt = 0;
    run_cmd = 1; tick; run_cmd = 0;
    repeat (20) tick;
    check("sat_count4", cycle_count4, 15);
    clr_cnt = 1; tick; clr_cnt = 0;
    check("clr_count4", cycle_count4, 0);
    check("clr_count", cycle_count, 0);
    halt_cmd = 1; tick; halt_cmd = 0;

    // Reset mid-RUN, dropped between edges
    run_cmd = 1; tick; run_cmd = 0;
    repeat (3) tick;
    #2 reset_n = 1'b0;
    #1;
    check("arst_state", state, 0);
    check("arst_enable", enable, 0);
    check("arst_count", cycle_count, 0);
    @(negedge clock); #1 reset_n = 1'b1;

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      tick;
      run_cmd      = ($urandom_range(0, 11) == 0);
      step_cmd     = ($urandom_range(0, 7) == 0);
      halt_cmd     = ($urandom_range(0, 19) == 0);
      halt_instr   = ($urandom_range(0, 14) == 0);
      clr_cnt      = ($urandom_range(0, 40) == 0);
      EX_mem_read  = ($urandom_range(0, 2) == 0);
      EX_rt        = 5'($urandom_range(0, 3));
      ID_rs        = 5'($urandom_range(0, 3));
      ID_rt        = 5'($urandom_range(0, 3));
      branch_taken = ($urandom_range(0, 5) == 0);
      jump_sel     = ($urandom_range(0, 7) == 0);
    end
    clear_inputs;
    tick;
    @(negedge clock);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
